pwm_gen: RTL and testbench

- Downstream consumer of the free-running `counter` block.
- Takes the counter's `count` value and produces a PWM waveform whose duty is programmed through a valid/ready handshake.
- Duty updates are double-buffered and take effect only at a period boundary, so no glitched periods occur.
- Also detects count discontinuities from the upstream counter, such as a stuck value or an independent reset.

---
 rtl/pwm_gen.sv | 81 ++++++++
 tb/tb_pwm_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// PWM generator driven by an external free-running count.
// Duty is double-buffered and applied at the period wrap.
module pwm_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [WIDTH:0]   duty_active,
  output logic             pwm,
  output logic             period_start,
  output logic             sync_err
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH:0]   FULL = (WIDTH+1)'(1) << WIDTH;

  logic             pending;
  logic [WIDTH:0]   pending_val;
  logic [WIDTH-1:0] prev_count;
  logic             arm;

  logic             accept;
  logic             at_max;
  logic [WIDTH:0]   duty_clamped;
  logic [WIDTH:0]   active_nxt;
  logic [WIDTH:0]   pval_nxt;
  logic             pending_nxt;
  logic [WIDTH-1:0] exp_count;

  assign duty_ready   = ~pending;
  assign accept       = duty_valid & duty_ready;
  assign at_max       = (count == MAX);
  assign duty_clamped = (duty_in > FULL) ? FULL : duty_in;
  assign exp_count    = prev_count + 1'b1;

  // Accept and apply are exclusive since ready is low while pending.
  always_comb begin
    active_nxt  = duty_active;
    pval_nxt    = pending_val;
    pending_nxt = pending;
    if (at_max && pending) begin
      active_nxt  = pending_val;
      pending_nxt = 1'b0;
    end else if (accept) begin
      if (at_max) begin
        active_nxt = duty_clamped;
      end else begin
        pval_nxt    = duty_clamped;
        pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_active  <= '0;
      pending      <= 1'b0;
      pending_val  <= '0;
      pwm          <= 1'b0;
      period_start <= 1'b0;
      prev_count   <= '0;
      arm          <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      duty_active  <= active_nxt;
      pending      <= pending_nxt;
      pending_val  <= pval_nxt;
      pwm          <= ({1'b0, count} < active_nxt);
      period_start <= (count == '0);
      prev_count   <= count;
      arm          <= 1'b1;
      if (arm && (count != exp_count))
        sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed testbench for pwm_gen with WIDTH=4.
// The bench drives count itself so it can inject discontinuities.
module tb_pwm_gen;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic [4:0] duty_active;
  logic       pwm;
  logic       period_start;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] smp;

  pwm_gen #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_active  (duty_active),
    .pwm          (pwm),
    .period_start (period_start),
    .sync_err     (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    smp = count;
    #1;
    count = count + 1'b1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("pwm", 32'(pwm), 32'(int'(smp) < d));
      chk("period_start", 32'(period_start), 32'(smp == 4'd0));
    end
  endtask

  initial begin
    rst        = 1'b1;
    count      = 4'd0;
    duty_in    = 5'd0;
    duty_valid = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_active", 32'(duty_active), 0);
    chk("rst_ready", 32'(duty_ready), 1);
    chk("rst_sync", 32'(sync_err), 0);
    rst = 1'b0;

    // idle: no duty written
    for (int i = 0; i < 14; i++) tick();
    run(32, 0);
    chk("idle_ready", 32'(duty_ready), 1);
    chk("idle_sync", 32'(sync_err), 0);

    // duty 5 written at count 3
    run(3, 0);
    duty_in = 5'd5;
    duty_valid = 1'b1;
    run(1, 0);
    duty_valid = 1'b0;
    chk("d5_ready_lo", 32'(duty_ready), 0);
    chk("d5_active_old", 32'(duty_active), 0);
    run(11, 0);
    chk("d5_ready_hold", 32'(duty_ready), 0);
    run(1, 0);
    chk("d5_active", 32'(duty_active), 5);
    chk("d5_ready_back", 32'(duty_ready), 1);
    run(16, 5);

    // duty 0
    run(2, 5);
    duty_in = 5'd0;
    duty_valid = 1'b1;
    run(1, 5);
    duty_valid = 1'b0;
    run(13, 5);
    chk("d0_active", 32'(duty_active), 0);
    run(16, 0);

    // duty 16: applying edge at count 15 already sees 15<16
    run(2, 0);
    duty_in = 5'd16;
    duty_valid = 1'b1;
    run(1, 0);
    duty_valid = 1'b0;
    run(12, 0);
    tick();
    chk("d16_wrap_pwm", 32'(pwm), 1);
    chk("d16_active", 32'(duty_active), 16);
    run(16, 16);

    // duty 20 clamps to 16
    run(2, 16);
    duty_in = 5'd20;
    duty_valid = 1'b1;
    run(1, 16);
    duty_valid = 1'b0;
    run(13, 16);
    chk("clamp_active", 32'(duty_active), 16);
    run(16, 16);

    // accept exactly at count 15 with nothing pending
    run(15, 16);
    duty_in = 5'd9;
    duty_valid = 1'b1;
    tick();
    chk("sim_pwm", 32'(pwm), 0);
    chk("sim_active", 32'(duty_active), 9);
    chk("sim_ready", 32'(duty_ready), 1);
    run(1, 9);
    duty_valid = 1'b0;
    chk("sim_second_take", 32'(duty_ready), 0);
    run(15, 9);
    chk("sim_ready_back", 32'(duty_ready), 1);
    chk("sim_active2", 32'(duty_active), 9);

    // 7 pending, 3 presented while not ready
    run(2, 9);
    duty_in = 5'd7;
    duty_valid = 1'b1;
    run(1, 9);
    duty_in = 5'd3;
    run(12, 9);
    chk("bp_ready", 32'(duty_ready), 0);
    chk("bp_active_old", 32'(duty_active), 9);
    run(1, 9);
    chk("bp_active7", 32'(duty_active), 7);
    chk("bp_ready_back", 32'(duty_ready), 1);
    run(1, 7);
    duty_valid = 1'b0;
    chk("bp_took3", 32'(duty_ready), 0);
    run(14, 7);
    chk("bp_active_still7", 32'(duty_active), 7);
    run(1, 7);
    chk("bp_active3", 32'(duty_active), 3);
    run(16, 3);

    // count frozen at 6 for two cycles
    run(6, 3);
    tick();
    chk("frz_before", 32'(sync_err), 0);
    count = 4'd6;
    tick();
    chk("frz_err", 32'(sync_err), 1);
    run(4, 3);
    chk("frz_sticky", 32'(sync_err), 1);

    // reset mid-operation discards a pending duty
    duty_in = 5'd12;
    duty_valid = 1'b1;
    run(1, 3);
    duty_valid = 1'b0;
    chk("mid_pending", 32'(duty_ready), 0);
    rst = 1'b1;
    tick();
    tick();
    chk("mid_pwm", 32'(pwm), 0);
    chk("mid_active", 32'(duty_active), 0);
    chk("mid_ready", 32'(duty_ready), 1);
    chk("mid_sync", 32'(sync_err), 0);
    chk("mid_ps", 32'(period_start), 0);
    rst = 1'b0;
    run(2, 0);
    chk("mid_discard", 32'(duty_active), 0);

    // count jumps from 8 to 0
    run(8, 0);
    chk("jmp_before", 32'(sync_err), 0);
    run(1, 0);
    count = 4'd0;
    run(1, 0);
    chk("jmp_err", 32'(sync_err), 1);
    run(15, 0);
    chk("jmp_sticky", 32'(sync_err), 1);

    rst = 1'b1;
    tick();
    chk("clr_sync", 32'(sync_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
